bsg_manycore_link_sdr_reset_seq: RTL
====================================

BSG_MANYCORE_LINK_SDR_RESET_SEQ -- requirements
Module: bsg_manycore_link_sdr_reset_seq

Interface
REQ-001 SHALL have parameter phase_cycles_p, default 16: cycles spent in each timed phase; legal range 1..65536.
REQ-002 SHALL have port clk_i, input, 1: sole clock; the downstream SDR link pair's core clock.
REQ-003 SHALL have port reset_n_i, input, 1: synchronous, active-low reset.
REQ-004 SHALL have port start_i, input, 1: level-sampled request to run the link reset sequence.
REQ-005 SHALL have port uplink_reset_o, output, 1: drives the SDR link async uplink reset.
REQ-006 SHALL have port downlink_reset_o, output, 1: drives the SDR link async downlink reset.
REQ-007 SHALL have port downstream_reset_o, output, 1: drives the SDR link async downstream reset.
REQ-008 SHALL have port token_reset_o, output, 1: drives the SDR link async token reset.
REQ-009 SHALL have port busy_o, output, 1: high while a sequence is in progress.
REQ-010 SHALL have port done_o, output, 1: high once the sequence has completed and the link is released.

Function
REQ-011 SHALL implement states IDLE, ASSERT, TOK_HI, TOK_LO, UP_REL, DN_REL and DONE.
REQ-012 SHALL drive all outputs directly from flops, with no combinational path from any input to any output, because the outputs feed asynchronous resets.
REQ-013 Output values per state (up/down/ds/tok):
- IDLE and ASSERT: 1/1/1/0.
- TOK_HI: 1/1/1/1.
- TOK_LO: 1/1/1/0.
- UP_REL: 0/1/1/0.
- DN_REL: 0/0/1/0.
- DONE: 0/0/0/0.
REQ-014 SHALL drive busy_o=1 in states ASSERT through DN_REL and 0 otherwise; done_o=1 only in DONE.
REQ-015 start_i=1 sampled in IDLE or DONE SHALL move the block to ASSERT on the next edge; the new values appear the cycle after sampling.
REQ-016 SHALL remain in each of ASSERT, TOK_HI, TOK_LO, UP_REL and DN_REL for exactly phase_cycles_p cycles, then advance in the listed order; DN_REL advances to DONE.
REQ-017 Latency: start sampled at edge k gives done_o=1 from cycle k+1+5*phase_cycles_p.
REQ-018 start_i SHALL be ignored while busy_o=1; there is no abort and no restart of the phase count.
REQ-019 start_i in DONE SHALL restart the sequence, re-asserting all link resets on the next cycle.
REQ-020 SHALL hold the phase counter at width max(1,$clog2(phase_cycles_p)) bits, clear it on every state entry, and advance the state when count==phase_cycles_p-1.
REQ-021 phase_cycles_p=1 SHALL give one-cycle phases with no counter overflow.
REQ-022 SHALL hold IDLE and DONE indefinitely without start_i.

Reset
REQ-023 reset_n_i=0 at an edge SHALL force state IDLE, counter 0, up/down/ds=1, tok=0, busy_o=0 and done_o=0 on the next cycle.
REQ-024 Reset SHALL take priority over start_i and take effect mid-sequence in any state.

Configuration
REQ-025 With macro BSG_MANYCORE_LINK_SDR_RESET_SEQ_COUNT_EN defined, SHALL add output seq_count_o [7:0].
- Resets to 0.
- Increments by 1 on every entry to DONE.
- Wraps 255 to 0.
REQ-026 Without that macro, seq_count_o and its register SHALL be absent, with all other behaviour identical.

Structure
REQ-027 SHALL define the state enum typedef bsg_manycore_link_sdr_reset_seq_state_e (3 bits) in bsg_manycore_pkg.
REQ-028 SHALL place the phase counter in a sub-module, bsg_manycore_link_sdr_reset_seq_phase_ctr, with clear, enable and terminal-count ports.
REQ-029 SHALL keep all other logic, including state register, output decode flops and optional count, in the top module.

Verification
REQ-030 The bench SHALL cover the following directed scenarios, run at phase_cycles_p=4 unless stated:
- Nominal sequence: start pulse at cycle 0 -> ASSERT cycles 1-4, TOK_HI 5-8, TOK_LO 9-12, UP_REL 13-16, DN_REL 17-20, done_o=1 from cycle 21, outputs per REQ-013.
- Start ignored while busy: start held high through cycles 0-30 -> one sequence only, done_o at cycle 21, then restart ASSERT at cycle 22.
- Reset mid-sequence: reset_n_i=0 at cycle 10 (TOK_LO) -> cycle 11 shows IDLE values; start at cycle 15 -> done_o at cycle 36.
- Minimum phase length: phase_cycles_p=1, start at 0 -> states change every cycle, done_o at cycle 6.
- Count macro: with the macro defined, 257 back-to-back sequences -> seq_count_o=1; without the macro the module compiles and seq_count_o is absent.
- Reset value: reset_n_i held low for 3 cycles with start_i=1 -> up/down/ds=1, tok=0, busy_o=0 and done_o=0 throughout.

Source files
------------

// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore SDR link reset sequencer: state encoding,
// the registered output bundle, and the per-state output decode.
package bsg_manycore_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ASSERT = 3'd1,
    TOK_HI = 3'd2,
    TOK_LO = 3'd3,
    UP_REL = 3'd4,
    DN_REL = 3'd5,
    DONE   = 3'd6
  } bsg_manycore_link_sdr_reset_seq_state_e;

  typedef struct packed {
    logic up;
    logic down;
    logic ds;
    logic tok;
    logic busy;
    logic done;
  } link_out_s;

  function automatic int phase_ctr_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  // Link resets are released upstream-first; the token is toggled while all are held.
  function automatic link_out_s decode_state(input bsg_manycore_link_sdr_reset_seq_state_e s);
    link_out_s o;
    o = '{up: 1'b1, down: 1'b1, ds: 1'b1, tok: 1'b0, busy: 1'b0, done: 1'b0};
    case (s)
      ASSERT:  o.busy = 1'b1;
      TOK_HI:  begin o.tok = 1'b1; o.busy = 1'b1; end
      TOK_LO:  o.busy = 1'b1;
      UP_REL:  begin o.up = 1'b0; o.busy = 1'b1; end
      DN_REL:  begin o.up = 1'b0; o.down = 1'b0; o.busy = 1'b1; end
      DONE:    begin o.up = 1'b0; o.down = 1'b0; o.ds = 1'b0; o.done = 1'b1; end
      default: o.busy = 1'b0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/bsg_manycore_link_sdr_reset_seq_phase_ctr.sv
// Phase-length counter for the link reset sequencer: cleared on each state
// entry, counts while enabled, flags the last cycle of a phase.
module bsg_manycore_link_sdr_reset_seq_phase_ctr
  import bsg_manycore_pkg::*;
#(
  parameter int phase_cycles_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic clear_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int width_lp = phase_ctr_width(phase_cycles_p);

  logic [width_lp-1:0] count_r;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i || clear_i) begin
      count_r <= '0;
    end else if (en_i) begin
      count_r <= count_r + 1'b1;
    end
  end

  // The state leaves on tc, which clears the count, so it never wraps.
  assign tc_o = (count_r == width_lp'(phase_cycles_p - 1));

endmodule

// File: rtl/bsg_manycore_link_sdr_reset_seq.sv
// Sequences the async resets of an SDR link pair. All outputs are flops.
// Define BSG_MANYCORE_LINK_SDR_RESET_SEQ_COUNT_EN to add seq_count_o.
module bsg_manycore_link_sdr_reset_seq
  import bsg_manycore_pkg::*;
#(
  parameter int phase_cycles_p = 16
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  output logic       uplink_reset_o,
  output logic       downlink_reset_o,
  output logic       downstream_reset_o,
  output logic       token_reset_o,
  output logic       busy_o,
  output logic       done_o
`ifdef BSG_MANYCORE_LINK_SDR_RESET_SEQ_COUNT_EN
  ,
  output logic [7:0] seq_count_o
`endif
);

  bsg_manycore_link_sdr_reset_seq_state_e state_r, state_n;
  link_out_s out_n, out_r;
  logic      tc;
  logic      timed;

  assign timed = (state_r != IDLE) && (state_r != DONE);

  bsg_manycore_link_sdr_reset_seq_phase_ctr #(
    .phase_cycles_p(phase_cycles_p)
  ) phase_ctr (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .clear_i  (state_n != state_r),
    .en_i     (timed),
    .tc_o     (tc)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // NOTE: state_n gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state_r;
    case (state_r)
      IDLE, DONE: if (start_i) state_n = ASSERT;
      ASSERT:     if (tc) state_n = TOK_HI;
      TOK_HI:     if (tc) state_n = TOK_LO;
      TOK_LO:     if (tc) state_n = UP_REL;
      UP_REL:     if (tc) state_n = DN_REL;
      DN_REL:     if (tc) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  // Decoding the next state and registering it keeps outputs glitch-free.
  always_comb begin
    out_n = decode_state(state_n);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      out_r <= decode_state(IDLE);
    end else begin
      out_r <= out_n;
    end
  end

  assign uplink_reset_o     = out_r.up;
  assign downlink_reset_o   = out_r.down;
  assign downstream_reset_o = out_r.ds;
  assign token_reset_o      = out_r.tok;
  assign busy_o             = out_r.busy;
  assign done_o             = out_r.done;

`ifdef BSG_MANYCORE_LINK_SDR_RESET_SEQ_COUNT_EN
  logic [7:0] seq_count_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      seq_count_r <= '0;
    end else if (state_n == DONE && state_r != DONE) begin
      seq_count_r <= seq_count_r + 8'd1;
    end
  end

  assign seq_count_o = seq_count_r;
`endif

endmodule
